// File: rtl/key_debounce.sv
`timescale 1ns/1ps
// Purpose: synchronise and debounce active-low push keys; clean level plus press/release strobes per key.
// Latency: raw key_n edge to key_value/strobe update is 2 (synchroniser) + CNT_MAX sys_clk cycles.
// Backpressure: none; free-running sampler, strobes are single-cycle and must be consumed when seen.
//
// Ports:
//   sys_clk      system clock
//   sys_rst      synchronous reset, active-high
//   key_n        raw key pins, active-low, asynchronous to sys_clk
//   key_value    debounced level, active-high (1 = pressed)
//   key_press    one-cycle pulse on key_value 0->1
//   key_release  one-cycle pulse on key_value 1->0
module key_debounce #(
  parameter int N_KEYS  = 4,
  parameter int CNT_MAX = 1_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_value,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int             CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  // Last count before a change is accepted; the compare bounds the counter so it never wraps.
  localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX - 1);

  // Two-flop synchroniser on the raw pins. Reset value is all-ones (keys released).
  logic [N_KEYS-1:0] key_meta;
  logic [N_KEYS-1:0] key_sync;
  logic [N_KEYS-1:0] key_s;
  logic [CW-1:0]     cnt [N_KEYS];

  // Synchronised level, converted to active-high.
  assign key_s = ~key_sync;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      key_meta    <= '1;
      key_sync    <= '1;
      key_value   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
      for (int i = 0; i < N_KEYS; i++) begin
        key_press[i]   <= 1'b0;
        key_release[i] <= 1'b0;
        if (key_s[i] == key_value[i]) begin
          // Agreement with the accepted level (including any bounce back) restarts the count.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          // CNT_MAX consecutive differing cycles seen: accept the new level and strobe once.
          key_value[i]   <= key_s[i];
          key_press[i]   <= key_s[i];
          key_release[i] <= ~key_s[i];
          cnt[i]         <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
`timescale 1ns/1ps
// Purpose: directed self-checking bench for key_debounce with a strobe scoreboard.
// Latency: every accepted change expected 10 cycles (2 sync + CNT_MAX=8) after the drive.
// Backpressure: not applicable; the monitor consumes every strobe as it appears.
module tb_key_debounce;

  localparam int N_KEYS  = 4;
  localparam int CNT_MAX = 8;
  localparam int LAT     = 2 + CNT_MAX;

  logic              clk;
  logic              sys_rst;
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] key_value;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  value;
    string       tag;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;

  key_debounce #(
    .N_KEYS  (N_KEYS),
    .CNT_MAX (CNT_MAX)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (sys_rst),
    .key_n       (key_n),
    .key_value   (key_value),
    .key_press   (key_press),
    .key_release (key_release)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Any strobe must match the oldest pending expectation, cycle-exact.
  always @(negedge clk) begin
    if ((key_press | key_release) != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'({key_press, key_release}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_cycle"},   32'(cyc),         32'(mon_e.cyc));
        check({mon_e.tag, "_press"},   32'(key_press),   32'(mon_e.press));
        check({mon_e.tag, "_release"}, 32'(key_release), 32'(mon_e.rel));
        check({mon_e.tag, "_value"},   32'(key_value),   32'(mon_e.value));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic [3:0] press, input logic [3:0] rel,
                            input logic [3:0] value, input string tag);
    sb_t e;
    e.cyc   = cyc + LAT;
    e.press = press;
    e.rel   = rel;
    e.value = value;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 4 * LAT) begin
      step(1);
      n++;
    end
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    step(2);
  endtask

  initial begin
    sys_rst = 1'b1;
    key_n   = 4'b0000;

    // 1: reset with all keys held, then acceptance of the held level.
    step(3);
    check("rst_value",   32'(key_value),   32'd0);
    check("rst_press",   32'(key_press),   32'd0);
    check("rst_release", 32'(key_release), 32'd0);
    sys_rst = 1'b0;
    expect_evt(4'b1111, 4'b0000, 4'b1111, "rst_accept");
    step(LAT - 1);
    check("rst_pre_accept", 32'(key_value), 32'd0);
    drain("rst_accept");
    key_n = 4'b1111;
    expect_evt(4'b0000, 4'b1111, 4'b0000, "rel_all");
    drain("rel_all");

    // 2: clean press and release on key 0.
    key_n = 4'b1110;
    expect_evt(4'b0001, 4'b0000, 4'b0001, "clean_press");
    step(LAT - 1);
    check("clean_early", 32'({key_press, key_value}), 32'd0);
    drain("clean_press");
    check("clean_hold", 32'(key_value), 32'(4'b0001));
    key_n = 4'b1111;
    expect_evt(4'b0000, 4'b0001, 4'b0000, "clean_rel");
    drain("clean_rel");

    // 3: key 1 bounces every 3 cycles for ~40 cycles, then settles pressed.
    for (int i = 0; i < 14; i++) begin
      key_n = {2'b11, i[0], 1'b1};
      step(3);
    end
    check("bounce_value", 32'(key_value), 32'd0);
    key_n = 4'b1101;
    expect_evt(4'b0010, 4'b0000, 4'b0010, "bounce_press");
    drain("bounce_press");
    key_n = 4'b1111;
    expect_evt(4'b0000, 4'b0010, 4'b0000, "bounce_rel");
    drain("bounce_rel");

    // 4: 7-cycle glitch on key 2 must be rejected.
    key_n = 4'b1011;
    step(CNT_MAX - 1);
    key_n = 4'b1111;
    step(3 * LAT);
    check("glitch_value", 32'(key_value), 32'd0);

    // 5: keys 0 and 3 pressed together strobe in the same cycle.
    key_n = 4'b0110;
    expect_evt(4'b1001, 4'b0000, 4'b1001, "simul_press");
    drain("simul_press");
    key_n = 4'b1111;
    expect_evt(4'b0000, 4'b1001, 4'b0000, "simul_rel");
    drain("simul_rel");

    // 6: reset at count 5 while key 1 is held discards the partial count.
    key_n = 4'b1101;
    step(7);
    sys_rst = 1'b1;
    step(1);
    sys_rst = 1'b0;
    check("midrst_value", 32'(key_value), 32'd0);
    expect_evt(4'b0010, 4'b0000, 4'b0010, "midrst_press");
    drain("midrst_press");
    key_n = 4'b1111;
    expect_evt(4'b0000, 4'b0010, 4'b0000, "midrst_rel");
    drain("midrst_rel");

    step(LAT);
    check("final_value", 32'(key_value), 32'd0);
    check("sb_empty",    32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
